// File: rtl/sys_pkg.sv
// Shared types and default timing constants for the reset sequencer and its users.
package sys_pkg;

  localparam int unsigned STATE_W             = 3;
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned PWRUP_CYCLES_50M    = 10000;  // 200us at 50MHz
  localparam int unsigned SOFT_RST_CYCLES_DEF = 16;
  localparam int unsigned INIT_TIMEOUT_DEF    = 65535;

  typedef enum logic [STATE_W-1:0] {
    HOLD  = 3'd0,
    PWRUP = 3'd1,
    INIT  = 3'd2,
    RUN   = 3'd3,
    SOFT  = 3'd4
  } seq_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sys_rst_seq_if.sv
// Reset-sequencer control/status bundle; master is the sequencer, slave the SDRAM/system side.
interface sys_rst_seq_if;
  import sys_pkg::*;

  logic               soft_rst_req;
  logic               init_done;
  logic               sys_rst_n;
  logic               init_req;
  logic               sys_ready;
  logic               init_timeout;
  logic [STATE_W-1:0] seq_state;

  modport master (
    input  soft_rst_req, init_done,
    output sys_rst_n, init_req, sys_ready, init_timeout, seq_state
  );

  modport slave (
    output soft_rst_req, init_done,
    input  sys_rst_n, init_req, sys_ready, init_timeout, seq_state
  );

endinterface

// File: rtl/rst_sync_chain.sv
// Async-assert / sync-release reset synchronizer; reusable for any secondary clock domain.
module rst_sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_ok
);

  logic [STAGES-1:0] chain_q;

  // Shift ones in from the bottom; output is the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= (chain_q << 1) | STAGES'(1);
    end
  end

  assign sync_ok = chain_q[STAGES-1];

endmodule

// File: rtl/sys_rst_seq.sv
// Board reset sequencer: synchronized release, SDRAM power-up wait, init handshake, soft reset.
module sys_rst_seq
  import sys_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned PWRUP_CYCLES    = PWRUP_CYCLES_50M,
  parameter int unsigned SOFT_RST_CYCLES = SOFT_RST_CYCLES_DEF,
  parameter int unsigned INIT_TIMEOUT    = INIT_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  sys_rst_seq_if.master bus
);

  localparam int unsigned CNT_MAX = max3(PWRUP_CYCLES, INIT_TIMEOUT, SOFT_RST_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_RST_CYCLES - 1);

  logic               sync_ok;
  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               init_req_q, init_req_d;
  logic               sys_ready_q, sys_ready_d;
  logic [STATE_W-1:0] seq_state_q, seq_state_d;

  rst_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync_ok (sync_ok)
  );

  // Next state, counter and timeout flag; outputs decode from next state so they land with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    timeout_d = timeout_q;

    case (state_q)
      HOLD: begin
        cnt_d = '0;
        if (sync_ok) state_d = PWRUP;
      end
      PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      INIT: begin
        // Soft reset beats completion; completion beats a coincident timeout.
        if (bus.soft_rst_req) begin
          state_d = SOFT;
          cnt_d   = '0;
        end else if (bus.init_done) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == INIT_LAST) begin
          state_d   = RUN;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (bus.soft_rst_req) state_d = SOFT;
      end
      SOFT: begin
        // A repeat request restarts the hold-off, stretching the reset.
        if (bus.soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == SOFT_LAST) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase

    sys_rst_n_d = (state_d == INIT) || (state_d == RUN);
    init_req_d  = (state_d == INIT);
    sys_ready_d = (state_d == RUN);
    seq_state_d = STATE_W'(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      sys_rst_n_q <= 1'b0;
      init_req_q  <= 1'b0;
      sys_ready_q <= 1'b0;
      seq_state_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      sys_rst_n_q <= sys_rst_n_d;
      init_req_q  <= init_req_d;
      sys_ready_q <= sys_ready_d;
      seq_state_q <= seq_state_d;
    end
  end

  assign bus.sys_rst_n    = sys_rst_n_q;
  assign bus.init_req     = init_req_q;
  assign bus.sys_ready    = sys_ready_q;
  assign bus.init_timeout = timeout_q;
  assign bus.seq_state    = seq_state_q;

endmodule

// File: tb/tb_sys_rst_seq.sv
// Scoreboard bench for sys_rst_seq: output-change events predicted from the sequencing rules.
`timescale 1ns/1ps
module tb_sys_rst_seq;
  import sys_pkg::*;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned PWR   = 8;
  localparam int unsigned SOFTN = 4;
  localparam int unsigned TOUT  = 20;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   errors = 0;
  int   checks = 0;
  bit   to_m   = 1'b0;
  exp_t exp_q[$];

  sys_rst_seq_if bus();

  sys_rst_seq #(
    .SYNC_STAGES     (SYNC),
    .PWRUP_CYCLES    (PWR),
    .SOFT_RST_CYCLES (SOFTN),
    .INIT_TIMEOUT    (TOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {sys_rst_n, init_req, sys_ready, init_timeout, seq_state}
  logic [6:0] obs;
  assign obs = {bus.sys_rst_n, bus.init_req, bus.sys_ready, bus.init_timeout, bus.seq_state};

  function automatic logic [6:0] mk(input bit rn, input bit rq, input bit rdy, input bit to,
                                    input logic [2:0] st);
    return {rn, rq, rdy, to, st};
  endfunction

  task automatic push(input int c, input logic [6:0] v);
    exp_q.push_back('{cyc: c, vec: v});
  endtask

  task automatic goto_neg(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of the observed outputs must match the next predicted event.
  logic [6:0] prev = '0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (obs !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got=%b", cyc, obs);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.vec !== obs) begin
          errors++;
          $display("FAIL event got cyc=%0d vec=%b, want cyc=%0d vec=%b", cyc, obs, e.cyc, e.vec);
        end
      end
    end
    prev = obs;
  end

  // Release of rst_n at negedge b: sync_ok after edge b+SYNC, PWRUP on the next edge, then PWR clocks.
  task automatic release_seq(input int b, output int p);
    goto_neg(b);
    rst_n = 1'b1;
    to_m  = 1'b0;
    push(b + SYNC + 1, mk(0, 0, 0, 0, 3'd1));
    p = b + SYNC + 1 + PWR;
    push(p, mk(1, 1, 0, 0, 3'd2));
  endtask

  // init_req rose at edge p; init_done seen at edge p+d (d=0: never).
  task automatic run_init(input int p, input int d, output int r);
    if (d >= 1 && d <= int'(TOUT)) begin
      r = p + d;
      push(r, mk(1, 0, 1, to_m, 3'd3));
    end else begin
      r    = p + TOUT;
      to_m = 1'b1;
      push(r, mk(1, 0, 1, 1, 3'd3));
    end
    if (d >= 1) begin
      goto_neg(p + d - 1);
      bus.init_done = 1'b1;
    end
    goto_neg(r);
  endtask

  // Soft pulse sampled at edge s+1; optional second pulse sampled at edge s+k+1 restarts the hold.
  task automatic soft_seq(input int s, input int k, output int x);
    x = s + 1 + SOFTN + k;
    push(s + 1, mk(0, 0, 0, to_m, 3'd4));
    push(x, mk(1, 1, 0, to_m, 3'd2));
    goto_neg(s);
    bus.init_done    = 1'b0;
    bus.soft_rst_req = 1'b1;
    @(negedge clk);
    bus.soft_rst_req = 1'b0;
    if (k > 0) begin
      goto_neg(s + k);
      bus.soft_rst_req = 1'b1;
      @(negedge clk);
      bus.soft_rst_req = 1'b0;
    end
  endtask

  task automatic pulse_soft_at(input int c);
    goto_neg(c);
    bus.soft_rst_req = 1'b1;
    @(negedge clk);
    bus.soft_rst_req = 1'b0;
  endtask

  initial begin : stim
    int p, r, x, d, k, g, f;
    bus.soft_rst_req = 1'b0;
    bus.init_done    = 1'b0;
    #5 rst_n = 1'b0;

    goto_neg(3);
    checks++;
    if (obs !== 7'd0) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 7'd0);
    end

    // Power-on: release at 100ns, init_done three clocks after init_req.
    release_seq(5, p);
    run_init(p, 3, r);

    // Soft reset with a second request two clocks in: six clocks low, no PWRUP.
    soft_seq(cyc + 3, 2, x);
    run_init(x, 3, r);

    // Random soft/init cycles, starting with done on the timeout edge and one clock after it.
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      d = TOUT;
      else if (i == 1) d = TOUT + 1;
      else             d = int'($urandom_range(1, 24));
      k = int'($urandom_range(0, 4));
      if (k == 1) k = 0;
      soft_seq(cyc + int'($urandom_range(1, 5)), k, x);
      run_init(x, d, r);
    end

    // Clean run, then init_done never arrives: timeout, sticky through later cycles.
    soft_seq(cyc + 2, 0, x);
    run_init(x, 5, r);
    soft_seq(cyc + 2, 0, x);
    run_init(x, 0, r);
    soft_seq(cyc + 2, 3, x);
    run_init(x, 5, r);

    // Short rst_n glitch mid-INIT: immediate clear, full replay; soft requests in HOLD/PWRUP ignored.
    soft_seq(cyc + 2, 0, x);
    g = x + 4;
    goto_neg(g - 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'd0) begin
      errors++;
      $display("FAIL async_clear got=%b want=%b", obs, 7'd0);
    end
    push(g, mk(0, 0, 0, 0, 3'd0));
    #1 rst_n = 1'b1;
    release_seq(g, p);
    pulse_soft_at(g + 1);
    pulse_soft_at(g + 5);
    run_init(p, 3, r);

    // Illegal state encoding from RUN: HOLD next edge, then the PWRUP/INIT sequence.
    goto_neg(cyc + 3);
    f = cyc + 1;
    bus.init_done = 1'b0;
    push(f, mk(0, 0, 0, to_m, 3'd0));
    push(f + 1, mk(0, 0, 0, to_m, 3'd1));
    push(f + 1 + PWR, mk(1, 1, 0, to_m, 3'd2));
    force dut.state_q = seq_state_t'(3'd6);
    #1 release dut.state_q;
    run_init(f + 1 + PWR, 4, r);

    goto_neg(r + 5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
